// File: rtl/core_mem_pkg.sv
// Shared constants and enums for the core memory arbiter: MMIO decode addresses,
// halt token, FSM states and read-owner tags.
package core_mem_pkg;

    localparam logic [31:0] MMIO_HALT_ADDR = 32'hF000_0000;
    localparam logic [31:0] MMIO_SIG_ADDR  = 32'hF000_0004;
    localparam logic [31:0] HALT_TOKEN     = 32'hCAFE_CAFE;

    typedef enum logic { ST_RUN, ST_HALTED } arb_state_t;

    typedef enum logic [1:0] { OWN_NONE, OWN_IMEM, OWN_DMEM } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break between fetch and data requests, one-hot grant {dmem, imem}.
// MEM_ARB_RR_EN selects round-robin on a tie; otherwise dmem wins and last_d is ignored.
module mem_arb_pick
    import core_mem_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_d,   // 1 = dmem granted most recently
    output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        gnt = 2'b00;
        if (req_i && req_d)
            gnt = last_d ? 2'b01 : 2'b10;
        else if (req_d)
            gnt = 2'b10;
        else if (req_i)
            gnt = 2'b01;
    end
`else
    logic unused_last;
    assign unused_last = last_d;

    always_comb begin
        gnt = 2'b00;
        if (req_d)
            gnt = 2'b10;
        else if (req_i)
            gnt = 2'b01;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one single-port memory, with SIG and HALT MMIO decode.
// Define MEM_ARB_RR_EN for round-robin tie-break; default build gives dmem fixed priority.
module mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              sysclk,
    input  logic              rst_in,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_gnt,
    output logic              imem_rvalid,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_req,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_gnt,
    output logic              dmem_rvalid,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sig_valid,
    output logic [DATA_W-1:0] sig_data,
    output logic              halted
);

    arb_state_t state_q, state_d;
    owner_t     owner_q;
    logic       last_d_q;
    logic [1:0] pick;
    logic       run, is_halt, is_sig, halt_wr, sig_wr, drop;

    mem_arb_pick u_pick (
        .req_i  (imem_req),
        .req_d  (dmem_req),
        .last_d (last_d_q),
        .gnt    (pick)
    );

    // Reset and HALTED both suppress grants combinationally.
    assign run      = (state_q == ST_RUN) && !rst_in;
    assign imem_gnt = run && pick[0];
    assign dmem_gnt = run && pick[1];

    assign is_halt = (dmem_addr == ADDR_W'(MMIO_HALT_ADDR));
    assign is_sig  = (dmem_addr == ADDR_W'(MMIO_SIG_ADDR));
    assign halt_wr = dmem_gnt && dmem_we && is_halt && (dmem_wdata == DATA_W'(HALT_TOKEN));
    assign sig_wr  = dmem_gnt && dmem_we && is_sig;
    assign drop    = halt_wr || sig_wr;

    assign mem_en    = imem_gnt || (dmem_gnt && !drop);
    assign mem_we    = dmem_gnt && dmem_we && !drop;
    assign mem_addr  = dmem_gnt ? dmem_addr[ADDR_W-1:2] : imem_addr[ADDR_W-1:2];
    assign mem_wdata = dmem_wdata;

    logic unused_imem_lsb;
    assign unused_imem_lsb = ^imem_addr[1:0];

    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_wr) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    assign halted = (state_q == ST_HALTED);

    // Memory returns read data one cycle later; remember who asked.
    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in)                    owner_q <= OWN_NONE;
        else if (imem_gnt)             owner_q <= OWN_IMEM;
        else if (dmem_gnt && !dmem_we) owner_q <= OWN_DMEM;
        else                           owner_q <= OWN_NONE;
    end

    assign imem_rvalid = (owner_q == OWN_IMEM);
    assign dmem_rvalid = (owner_q == OWN_DMEM);
    assign imem_rdata  = mem_rdata;
    assign dmem_rdata  = mem_rdata;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in)                    last_d_q <= 1'b0;
        else if (imem_gnt || dmem_gnt) last_d_q <= dmem_gnt;
    end
`else
    assign last_d_q = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in) begin
            sig_valid <= 1'b0;
            sig_data  <= '0;
        end else begin
            sig_valid <= sig_wr;
            if (sig_wr) sig_data <= dmem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read responses go through a scoreboard queue
// checked by an independent monitor; grants and MMIO effects checked inline.
module tb_mem_arbiter;

    logic        sysclk = 1'b0;
    logic        rst_in = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        sig_valid, halted;
    logic [31:0] sig_data;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [256];
    logic [31:0] got;
    logic [3:0]  tie_pat;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .sysclk(sysclk), .rst_in(rst_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sig_valid(sig_valid), .sig_data(sig_data), .halted(halted)
    );

    initial forever #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Single-port memory with one-cycle read latency.
    always @(posedge sysclk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    always @(negedge sysclk) begin
        if (!rst_in && (imem_rvalid || dmem_rvalid)) begin
            checks++;
            got = dmem_rvalid ? dmem_rdata : imem_rdata;
            if (imem_rvalid && dmem_rvalid) begin
                errors++;
                $display("FAIL rvalid_both: imem_rvalid=1 dmem_rvalid=1, only one allowed");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: imem=%b dmem=%b data=%h cycle %0d, no read pending",
                         imem_rvalid, dmem_rvalid, got, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_d !== dmem_rvalid || e.data !== got || e.due != cyc) begin
                    errors++;
                    $display("FAIL rvalid_resp: got port_d=%b data=%h cycle %0d, expected port_d=%b data=%h cycle %0d",
                             dmem_rvalid, got, cyc, e.is_d, e.data, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic expect_rd(input logic is_d, input logic [31:0] data);
        exp_t x;
        x.is_d = is_d;
        x.data = data;
        x.due  = cyc + 1;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        imem_req = 1'b0; imem_addr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic smp();
        @(negedge sysclk);
    endtask

    task automatic dwr(input logic [31:0] a, input logic [31:0] d);
        idle();
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'h0000_0013;
        mem_rdata  = '0;
        idle();
        repeat (2) @(posedge sysclk);
        smp();
        chk("rst_imem_gnt", imem_gnt, 0);
        chk("rst_dmem_gnt", dmem_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid", {imem_rvalid, dmem_rvalid}, 0);
        chk("rst_sig", {sig_valid, halted}, 0);
        chk("rst_sig_data", sig_data, 0);

        // Plain data write then read-back.
        step(); rst_in = 1'b0; dwr(32'h200, 32'hA5A5_A5A5);
        smp();
        chk("dwr_gnt", dmem_gnt, 1);
        chk("dwr_we", {mem_en, mem_we}, 2'b11);
        chk("dwr_addr", mem_addr, 30'h80);
        step(); dmem_we = 1'b0;
        smp();
        chk("drd_gnt", {dmem_gnt, mem_we}, 2'b10);
        expect_rd(1'b1, 32'hA5A5_A5A5);

        // Fetch only: same-cycle grant, data next cycle.
        step(); idle(); imem_req = 1'b1; imem_addr = 32'h100;
        smp();
        chk("if_gnt", {dmem_gnt, imem_gnt, mem_en, mem_we}, 4'b0110);
        chk("if_addr", mem_addr, 30'h40);
        expect_rd(1'b0, 32'h0000_0013);
        step(); idle();
        smp();

        // Tie for four cycles; bit k set = dmem expected in cycle k.
`ifdef MEM_ARB_RR_EN
        tie_pat = 4'b0101;
`else
        tie_pat = 4'b1111;
`endif
        step();
        imem_req = 1'b1; imem_addr = 32'h100;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            smp();
            chk($sformatf("tie_gnt%0d", k), {dmem_gnt, imem_gnt}, tie_pat[k] ? 2'b10 : 2'b01);
            expect_rd(tie_pat[k], tie_pat[k] ? 32'hA5A5_A5A5 : 32'h0000_0013);
        end
        step(); idle();
        smp();

        // SIG write: dropped from memory, registered pulse.
        step(); dwr(32'hF000_0004, 32'hDEAD_BEEF);
        smp();
        chk("sig_gnt", {dmem_gnt, mem_en, sig_valid}, 3'b100);
        step(); idle();
        smp();
        chk("sig_pulse", sig_valid, 1);
        chk("sig_data", sig_data, 32'hDEAD_BEEF);
        step();
        smp();
        chk("sig_end", sig_valid, 0);

        // Non-token write to HALT address passes through.
        step(); dwr(32'hF000_0000, 32'h1234_5678);
        smp();
        chk("hpass_en", {mem_en, mem_we}, 2'b11);
        chk("hpass_addr", mem_addr, 30'h3C00_0000);
        chk("hpass_wdata", mem_wdata, 32'h1234_5678);
        step(); idle();
        smp();
        chk("hpass_halted", halted, 0);

        // Reset the cycle after a read grant cancels the response.
        step(); imem_req = 1'b1; imem_addr = 32'h100;
        smp();
        chk("rp_gnt", imem_gnt, 1);
        step(); idle(); rst_in = 1'b1;
        smp();
        chk("rp_rvalid", {imem_rvalid, dmem_rvalid}, 0);
        chk("rp_outs", {imem_gnt, dmem_gnt, mem_en, sig_valid, halted}, 0);
        chk("rp_sig_data", sig_data, 0);
        step(); rst_in = 1'b0; imem_req = 1'b1; imem_addr = 32'h100;
        smp();
        chk("rp_regnt", {imem_gnt, imem_rvalid}, 2'b10);
        expect_rd(1'b0, 32'h0000_0013);
        step(); idle();
        smp();

        // Halt token: dropped from memory, then no more grants.
        step(); dwr(32'hF000_0000, 32'hCAFE_CAFE);
        smp();
        chk("halt_wr", {dmem_gnt, mem_en, halted}, 3'b100);
        step(); idle(); imem_req = 1'b1; imem_addr = 32'h100;
        smp();
        chk("halt_state", halted, 1);
        chk("halt_no_igrant", {imem_gnt, mem_en}, 0);
        step(); dmem_req = 1'b1; dmem_addr = 32'h200;
        smp();
        chk("halt_no_dgrant", {dmem_gnt, imem_gnt, halted}, 3'b001);
        step(); idle();
        smp();

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the word width of all data ports.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- sysclk  in  1  the single clock; all state changes on its rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- imem_req  in  1  instruction-fetch read request.
- imem_addr  in  ADDR_W  instruction-fetch byte address.
- imem_gnt  out  1  fetch request accepted this cycle.
- imem_rvalid  out  1  imem_rdata valid.
- imem_rdata  out  DATA_W  fetched word.
- dmem_req  in  1  data-port request.
- dmem_we  in  1  1 = write, 0 = read.
- dmem_addr  in  ADDR_W  data byte address.
- dmem_wdata  in  DATA_W  write data.
- dmem_gnt  out  1  data request accepted this cycle.
- dmem_rvalid  out  1  dmem_rdata valid.
- dmem_rdata  out  DATA_W  read word.
- mem_en  out  1  single-port memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W-2  word address (byte address bits [ADDR_W-1:2]).
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we = 0.
- sig_valid  out  1  one-cycle pulse: signature word written.
- sig_data  out  DATA_W  signature word.
- halted  out  1  sticky: halt token received.

Function
REQ-004 SHALL grant at most one requester per cycle; gnt is combinational from req, state and the arbitration pointer.
REQ-005 SHALL, on imem_gnt, drive mem_en = 1, mem_we = 0, mem_addr = imem_addr[ADDR_W-1:2] in the same cycle.
REQ-006 SHALL, on dmem_gnt to a non-MMIO address, drive mem_en = 1, mem_we = dmem_we, mem_addr from dmem_addr, mem_wdata = dmem_wdata.
REQ-007 SHALL register the read owner at grant and assert the owner's rvalid exactly one cycle after the granted read, with rdata = mem_rdata; rdata of the non-owner is don't-care.
REQ-008 SHALL generate no rvalid for writes or MMIO accesses.
REQ-009 SHALL decode byte address 0xF0000004 as SIG: a granted write does not reach memory, pulses sig_valid for one cycle (registered) and loads sig_data = dmem_wdata.
REQ-010 SHALL decode byte address 0xF0000000 as HALT: a granted write of 0xCAFECAFE does not reach memory and moves the FSM to HALTED; a write of any other value passes through to memory.
REQ-011 SHALL treat a granted MMIO read as a memory read (pass-through).
REQ-012 SHALL implement FSM states RUN and HALTED: RUN -> HALTED on the halt write; HALTED is left only by reset.
REQ-013 SHALL, in HALTED, assert halted = 1 and issue no further grants; an in-flight read still returns its rvalid.
REQ-014 SHALL, when only one requester is active, grant it immediately (no idle cycle).
REQ-015 SHALL apply the arbitration policy of REQ-019 when both requesters are active.

Reset
REQ-016 SHALL, while rst_in = 1, force all gnt, rvalid, sig_valid, halted and mem_en to 0, sig_data to 0, FSM to RUN, and the arbitration pointer to "imem last".
REQ-017 SHALL cancel any in-flight read on reset (no rvalid after release) and grant normally from the first edge after deassertion.

Configuration
REQ-018 SHALL use compile macro MEM_ARB_RR_EN.
REQ-019 SHALL, with MEM_ARB_RR_EN defined, use round-robin on a tie (grant the requester not granted most recently; the pointer updates on every grant); without it, dmem has fixed priority on a tie and the pointer logic is absent.

Structure
REQ-020 SHALL place MMIO_HALT_ADDR (0xF0000000), MMIO_SIG_ADDR (0xF0000004), HALT_TOKEN (0xCAFECAFE), and the FSM state and owner enums in the shared package core_mem_pkg.
REQ-021 SHALL keep the tie-break logic in one sub-module, mem_arb_pick (inputs: two requests and the last-grant pointer; output: a one-hot grant).

Verification
REQ-022 SHALL cover: imem_req only, addr 0x100, mem[0x40] = 0x00000013 -> imem_gnt in the same cycle, next cycle imem_rvalid = 1 with rdata 0x00000013.
REQ-023 SHALL cover: both requesting for 4 cycles, MEM_ARB_RR_EN on -> grants alternate dmem, imem, dmem, imem; with the macro off -> dmem granted all 4 cycles.
REQ-024 SHALL cover: dmem write 0xDEADBEEF to 0xF0000004 -> mem_en = 0, one-cycle sig_valid with sig_data = 0xDEADBEEF.
REQ-025 SHALL cover: dmem write 0xCAFECAFE to 0xF0000000 -> halted = 1 next cycle; a following imem_req receives no grant.
REQ-026 SHALL cover: dmem write 0x12345678 to 0xF0000000 -> forwarded to memory, halted stays 0.
REQ-027 SHALL cover: rst_in pulsed the cycle after a read grant -> no rvalid, all outputs 0, and the next imem_req is granted after release.
